// File: rtl/axi_lite_gpio_if.sv
// AXI4-Lite bus bundle for the GPIO block.
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where both valid and ready are 1; the source holds valid and its
// payload stable until that edge, and ready may not be assumed before it.
interface axi_lite_gpio_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_gpio.sv
// axi_lite_gpio: AXI4-Lite slave exposing up to 8 x 32-bit input channels
// (offsets 0x00+4k, read-only) and up to 8 x 32-bit output channels
// (offsets 0x20+4j, read/write). Only addr[7:2] is decoded.
// Write and read paths are independent three-state FSMs (IDLE/ACK/RESP);
// ready pulses come from the registered ACK state, responses from RESP.
// Optional build macro GPIO_IN_SYNC_EN: adds a 2-flop synchronizer on every
// gpio_i bit ahead of the read mux (2 extra clocks of input latency).
// o_dbg_state = {write state, read state}.
module axi_lite_gpio #(
    parameter int          I_PORT_COUNT  = 1,
    parameter int          O_PORT_COUNT  = 1,
    parameter logic [31:0] O_RESET_VALUE = 32'h0
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    axi_lite_gpio_if.slave        s_axi,
    input  logic [((I_PORT_COUNT == 0) ? 1 : 32*I_PORT_COUNT)-1:0] gpio_i,
    output logic [((O_PORT_COUNT == 0) ? 1 : 32*O_PORT_COUNT)-1:0] gpio_o,
    output logic [3:0]            o_dbg_state
);

    localparam int IW   = (I_PORT_COUNT == 0) ? 1 : 32*I_PORT_COUNT;
    localparam int IN_N = (I_PORT_COUNT == 0) ? 1 : I_PORT_COUNT;
    localparam int ON_N = (O_PORT_COUNT == 0) ? 1 : O_PORT_COUNT;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    wr_state_t   r_wr_state;
    wr_state_t   w_wr_next;
    rd_state_t   r_rd_state;
    rd_state_t   w_rd_next;

    logic        w_awready;
    logic        w_wready;
    logic        w_bvalid;
    logic        w_arready;
    logic        w_rvalid;

    logic [1:0]  r_bresp;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic [31:0] r_out [ON_N];
    logic [31:0] w_in_ch [IN_N];
    logic [IW-1:0] w_gpio_in;

    logic [2:0]  w_wr_idx;
    logic        w_wr_hit;
    logic [2:0]  w_rd_idx;
    logic [31:0] w_rd_data;
    logic        w_rd_err;

    // Address bits outside [7:2] and the prot fields carry no meaning here.
    logic        w_unused_bits;
    assign w_unused_bits = ^{s_axi.awprot, s_axi.arprot,
                             s_axi.awaddr[31:8], s_axi.awaddr[1:0],
                             s_axi.araddr[31:8], s_axi.araddr[1:0]};

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
`ifdef GPIO_IN_SYNC_EN
    logic [IW-1:0] r_sync1;
    logic [IW-1:0] r_sync2;

    // Two-stage synchronizer for asynchronous pins.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_gpio_in = r_sync2;
`else
    assign w_gpio_in = gpio_i;
`endif

    generate
        if (I_PORT_COUNT == 0) begin : g_no_in
            logic w_unused_gpio;
            assign w_unused_gpio = ^w_gpio_in;
            assign w_in_ch[0]    = 32'h0;
        end else begin : g_in
            for (genvar k = 0; k < I_PORT_COUNT; k++) begin : g_in_ch
                assign w_in_ch[k] = w_gpio_in[32*k +: 32];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign w_wr_idx = s_axi.awaddr[4:2];
    assign w_wr_hit = (s_axi.awaddr[7:5] == 3'b001) &&
                      ({29'd0, w_wr_idx} < O_PORT_COUNT);

    // Write FSM state register.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) r_wr_state <= W_IDLE;
        else              r_wr_state <= w_wr_next;
    end

    // Write FSM: accept only when address and data are both offered.
    always_comb begin
        w_wr_next = r_wr_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (s_axi.awvalid && s_axi.wvalid) w_wr_next = W_ACK;
            end
            W_ACK: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
                w_wr_next = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.bready) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Write response code, decided in the accept cycle and held through RESP.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset)            r_bresp <= RESP_OKAY;
        else if (r_wr_state == W_ACK) r_bresp <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
    end

    // Output registers: byte-masked update in the accept cycle.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int j = 0; j < ON_N; j++) r_out[j] <= O_RESET_VALUE;
        end else if ((r_wr_state == W_ACK) && w_wr_hit) begin
            for (int j = 0; j < O_PORT_COUNT; j++) begin
                if (w_wr_idx == 3'(j)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi.wstrb[b]) r_out[j][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    generate
        if (O_PORT_COUNT == 0) begin : g_no_out
            assign gpio_o = '0;
        end else begin : g_out
            for (genvar j = 0; j < O_PORT_COUNT; j++) begin : g_out_ch
                assign gpio_o[32*j +: 32] = r_out[j];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign w_rd_idx = s_axi.araddr[4:2];

    // Read mux; anything not matched falls through as SLVERR with zero data.
    always_comb begin
        w_rd_data = 32'h0;
        w_rd_err  = 1'b1;
        if (s_axi.araddr[7:5] == 3'b000) begin
            for (int k = 0; k < I_PORT_COUNT; k++) begin
                if (w_rd_idx == 3'(k)) begin
                    w_rd_data = w_in_ch[k];
                    w_rd_err  = 1'b0;
                end
            end
        end else if (s_axi.araddr[7:5] == 3'b001) begin
            for (int j = 0; j < O_PORT_COUNT; j++) begin
                if (w_rd_idx == 3'(j)) begin
                    w_rd_data = r_out[j];
                    w_rd_err  = 1'b0;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) r_rd_state <= R_IDLE;
        else              r_rd_state <= w_rd_next;
    end

    // Read FSM: one arready pulse, then hold rvalid until rready.
    always_comb begin
        w_rd_next = r_rd_state;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (s_axi.arvalid) w_rd_next = R_ACK;
            end
            R_ACK: begin
                w_arready = 1'b1;
                w_rd_next = R_RESP;
            end
            R_RESP: begin
                w_rvalid = 1'b1;
                if (s_axi.rready) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read data capture in the accept cycle; an output register written in
    // the same cycle is still seen with its old contents here.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_rdata <= 32'h0;
            r_rresp <= RESP_OKAY;
        end else if (r_rd_state == R_ACK) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

    assign o_dbg_state = {r_wr_state, r_rd_state};

endmodule

// File: tb/tb_axi_lite_gpio.sv
// Directed bench for axi_lite_gpio: one instance with 2 inputs / 1 output
// and a non-zero output reset value, plus one zero-port instance.
module tb_axi_lite_gpio;

    localparam logic [31:0] RST_VAL = 32'h0000_1234;

    logic        clk;
    logic        rst;
    logic [63:0] m_gpio_i;
    logic [31:0] m_gpio_o;
    logic [3:0]  m_dbg;
    logic [0:0]  z_gpio_i;
    logic [0:0]  z_gpio_o;
    logic [3:0]  z_dbg;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_gpio_if m_if ();
    axi_lite_gpio_if z_if ();

    axi_lite_gpio #(
        .I_PORT_COUNT (2),
        .O_PORT_COUNT (1),
        .O_RESET_VALUE(RST_VAL)
    ) u_dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .s_axi       (m_if.slave),
        .gpio_i      (m_gpio_i),
        .gpio_o      (m_gpio_o),
        .o_dbg_state (m_dbg)
    );

    axi_lite_gpio #(
        .I_PORT_COUNT (0),
        .O_PORT_COUNT (0),
        .O_RESET_VALUE(32'hFFFF_FFFF)
    ) u_dut_zero (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .s_axi       (z_if.slave),
        .gpio_i      (z_gpio_i),
        .gpio_o      (z_gpio_o),
        .o_dbg_state (z_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver tasks (main instance); each starts and ends 1 time unit
    // after a rising edge.
    // ------------------------------------------------------------------
    task automatic bus_idle();
        m_if.awaddr = '0; m_if.awprot = '0; m_if.awvalid = 1'b0;
        m_if.wdata  = '0; m_if.wstrb  = '0; m_if.wvalid  = 1'b0;
        m_if.bready = 1'b0;
        m_if.araddr = '0; m_if.arprot = '0; m_if.arvalid = 1'b0;
        m_if.rready = 1'b0;
        z_if.awaddr = '0; z_if.awprot = '0; z_if.awvalid = 1'b0;
        z_if.wdata  = '0; z_if.wstrb  = '0; z_if.wvalid  = 1'b0;
        z_if.bready = 1'b0;
        z_if.araddr = '0; z_if.arprot = '0; z_if.arvalid = 1'b0;
        z_if.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit got;
        resp = 2'b11;
        m_if.awaddr = a; m_if.wdata = d; m_if.wstrb = s;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1; m_if.bready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.awready && m_if.wready) got = 1'b1;
            @(posedge clk); #1;
        end
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL write_accept_timeout addr=%h: got no awready/wready, required within 20 cycles", a);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.bvalid) begin resp = m_if.bresp; got = 1'b1; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL write_resp_timeout addr=%h: got no bvalid, required within 20 cycles", a);
        end
        m_if.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        bit got;
        d = 32'hxxxx_xxxx; resp = 2'b11;
        m_if.araddr = a; m_if.arvalid = 1'b1; m_if.rready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.arready) got = 1'b1;
            @(posedge clk); #1;
        end
        m_if.arvalid = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL read_accept_timeout addr=%h: got no arready, required within 20 cycles", a);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.rvalid) begin d = m_if.rdata; resp = m_if.rresp; got = 1'b1; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL read_resp_timeout addr=%h: got no rvalid, required within 20 cycles", a);
        end
        m_if.rready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [4:0] hs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        hs = {m_if.awready, m_if.wready, m_if.arready, m_if.bvalid, m_if.rvalid};
        n_cmp++;
        if (hs !== 5'b0) begin n_err++; $display("FAIL reset_handshake: got %b, required 00000", hs); end
        n_cmp++;
        if (m_gpio_o !== RST_VAL) begin n_err++; $display("FAIL reset_gpio_o: got %h, required %h", m_gpio_o, RST_VAL); end
        n_cmp++;
        if ({m_if.bresp, m_if.rresp, m_if.rdata} !== 36'h0) begin
            n_err++; $display("FAIL reset_resp_data: got bresp=%b rresp=%b rdata=%h, required 00 00 0", m_if.bresp, m_if.rresp, m_if.rdata);
        end
        hs = {z_if.awready, z_if.wready, z_if.arready, z_if.bvalid, z_if.rvalid};
        n_cmp++;
        if (hs !== 5'b0 || z_gpio_o !== 1'b0) begin
            n_err++; $display("FAIL reset_zero_dut: got hs=%b gpio_o=%b, required 00000 0", hs, z_gpio_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_full();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(32'h20, 32'hA5A5_A5A5, 4'hF, r);
        n_cmp++;
        if (r !== 2'b00) begin n_err++; $display("FAIL full_write_bresp: got %b, required 00", r); end
        n_cmp++;
        if (m_gpio_o !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL full_write_gpio_o: got %h, required a5a5a5a5", m_gpio_o); end
        axi_read(32'h20, d, r);
        n_cmp++;
        if (d !== 32'hA5A5_A5A5 || r !== 2'b00) begin
            n_err++; $display("FAIL full_write_readback: got %h/%b, required a5a5a5a5/00", d, r);
        end
    endtask

    task automatic test_write_strobe();
        logic [1:0] r;
        axi_write(32'h20, 32'h1234_5678, 4'b0011, r);
        n_cmp++;
        if (m_gpio_o !== 32'hA5A5_5678 || r !== 2'b00) begin
            n_err++; $display("FAIL strobe_low_half: got %h/%b, required a5a55678/00", m_gpio_o, r);
        end
        axi_write(32'h20, 32'h3C00_00FF, 4'b1000, r);
        n_cmp++;
        if (m_gpio_o !== 32'h3CA5_5678 || r !== 2'b00) begin
            n_err++; $display("FAIL strobe_top_byte: got %h/%b, required 3ca55678/00", m_gpio_o, r);
        end
    endtask

    task automatic test_input_read();
        logic [1:0]  r;
        logic [31:0] d;
        m_gpio_i = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        repeat (4) @(posedge clk);
        #1;
        axi_read(32'h04, d, r);
        n_cmp++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            n_err++; $display("FAIL input_ch1_read: got %h/%b, required deadbeef/00", d, r);
        end
        axi_read(32'h00, d, r);
        n_cmp++;
        if (d !== 32'h0BAD_F00D || r !== 2'b00) begin
            n_err++; $display("FAIL input_ch0_read: got %h/%b, required 0badf00d/00", d, r);
        end
        axi_read(32'hFFFF_FF07, d, r);
        n_cmp++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            n_err++; $display("FAIL input_alias_read: got %h/%b, required deadbeef/00", d, r);
        end
        axi_write(32'h04, 32'h5555_5555, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10 || m_gpio_o !== 32'h3CA5_5678) begin
            n_err++; $display("FAIL input_write_slverr: got %b gpio_o=%h, required 10 3ca55678", r, m_gpio_o);
        end
    endtask

    task automatic test_unmapped();
        logic [1:0]  r;
        logic [31:0] d;
        axi_read(32'h08, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL unmapped_in_idx2: got %h/%b, required 0/10", d, r); end
        axi_read(32'h24, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL unmapped_out_idx1: got %h/%b, required 0/10", d, r); end
        axi_read(32'h40, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL unmapped_0x40: got %h/%b, required 0/10", d, r); end
        axi_write(32'h24, 32'hFFFF_FFFF, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10 || m_gpio_o !== 32'h3CA5_5678) begin
            n_err++; $display("FAIL unmapped_write_0x24: got %b gpio_o=%h, required 10 3ca55678", r, m_gpio_o);
        end
        axi_write(32'h60, 32'h0, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10 || m_gpio_o !== 32'h3CA5_5678) begin
            n_err++; $display("FAIL unmapped_write_0x60: got %b gpio_o=%h, required 10 3ca55678", r, m_gpio_o);
        end
    endtask

    task automatic test_back_to_back();
        bit         got;
        int         held;
        int         stray;
        logic [1:0] r1;
        logic [1:0] r2;
        m_if.awaddr = 32'h20; m_if.wdata = 32'h1111_1111; m_if.wstrb = 4'hF;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1; m_if.bready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.awready) got = 1'b1;
            @(posedge clk); #1;
        end
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL b2b_first_accept: got no awready, required within 20 cycles"); end
        // Offer a second write while the first response is still pending.
        m_if.wdata = 32'h2222_2222; m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
        held = 0; stray = 0; r1 = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m_if.bvalid) held++;
            if (c == 0) r1 = m_if.bresp;
            if (m_if.awready || m_if.wready) stray++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (held !== 5 || r1 !== 2'b00) begin n_err++; $display("FAIL b2b_bvalid_held: got %0d cycles bresp=%b, required 5 00", held, r1); end
        n_cmp++;
        if (stray !== 0) begin n_err++; $display("FAIL b2b_no_accept: got %0d ready cycles, required 0", stray); end
        n_cmp++;
        if (m_gpio_o !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_first_data: got %h, required 11111111", m_gpio_o); end
        m_if.bready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.awready) got = 1'b1;
            @(posedge clk); #1;
        end
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL b2b_second_accept: got no awready, required within 20 cycles"); end
        got = 1'b0; r2 = 2'b11;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.bvalid) begin r2 = m_if.bresp; got = 1'b1; end
            @(posedge clk); #1;
        end
        m_if.bready = 1'b0;
        n_cmp++;
        if (!got || r2 !== 2'b00 || m_gpio_o !== 32'h2222_2222) begin
            n_err++; $display("FAIL b2b_second_write: got seen=%0b bresp=%b gpio_o=%h, required 1 00 22222222", got, r2, m_gpio_o);
        end
    endtask

    task automatic test_concurrent();
        int          aw_at;
        int          ar_at;
        bit          b_got;
        bit          r_got;
        logic [1:0]  br;
        logic [1:0]  rr;
        logic [31:0] rd;
        m_if.awaddr = 32'h20; m_if.wdata = 32'h3333_3333; m_if.wstrb = 4'hF;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1; m_if.bready = 1'b1;
        m_if.araddr = 32'h20; m_if.arvalid = 1'b1; m_if.rready = 1'b1;
        aw_at = -1; ar_at = -1; b_got = 1'b0; r_got = 1'b0;
        br = 2'b11; rr = 2'b11; rd = 32'hx;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_if.awready && aw_at < 0) aw_at = c;
            if (m_if.arready && ar_at < 0) ar_at = c;
            if (m_if.bvalid && !b_got) begin b_got = 1'b1; br = m_if.bresp; end
            if (m_if.rvalid && !r_got) begin r_got = 1'b1; rr = m_if.rresp; rd = m_if.rdata; end
            @(posedge clk); #1;
            if (aw_at >= 0) begin m_if.awvalid = 1'b0; m_if.wvalid = 1'b0; end
            if (ar_at >= 0) m_if.arvalid = 1'b0;
        end
        m_if.bready = 1'b0; m_if.rready = 1'b0;
        n_cmp++;
        if (aw_at < 0 || ar_at !== aw_at) begin
            n_err++; $display("FAIL concurrent_accept_cycle: got aw=%0d ar=%0d, required equal and >=0", aw_at, ar_at);
        end
        n_cmp++;
        if (!r_got || rd !== 32'h2222_2222 || rr !== 2'b00) begin
            n_err++; $display("FAIL concurrent_read_old: got %h/%b, required 22222222/00", rd, rr);
        end
        n_cmp++;
        if (!b_got || br !== 2'b00 || m_gpio_o !== 32'h3333_3333) begin
            n_err++; $display("FAIL concurrent_write: got bresp=%b gpio_o=%h, required 00 33333333", br, m_gpio_o);
        end
    endtask

    task automatic test_zero_ports();
        int         aw_cnt;
        int         w_cnt;
        int         ar_cnt;
        logic [1:0] br;
        logic [1:0] rr;
        logic [4:0] idle_vec;
        z_if.awaddr = 32'h20; z_if.wdata = 32'hFFFF_FFFF; z_if.wstrb = 4'hF;
        z_if.araddr = 32'h00;
        z_if.awvalid = 1'b1; z_if.wvalid = 1'b1; z_if.arvalid = 1'b1;
        z_if.bready = 1'b1; z_if.rready = 1'b1;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; br = 2'b11; rr = 2'b11; idle_vec = 5'h1F;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (z_if.awready) aw_cnt++;
            if (z_if.wready)  w_cnt++;
            if (z_if.arready) ar_cnt++;
            if (z_if.bvalid)  br = z_if.bresp;
            if (z_if.rvalid)  rr = z_if.rresp;
            if (c == 4) idle_vec = {z_if.awready, z_if.wready, z_if.arready, z_if.bvalid, z_if.rvalid};
            @(posedge clk); #1;
            if (aw_cnt > 0) begin z_if.awvalid = 1'b0; z_if.wvalid = 1'b0; end
            if (ar_cnt > 0) z_if.arvalid = 1'b0;
        end
        z_if.bready = 1'b0; z_if.rready = 1'b0;
        n_cmp++;
        if (aw_cnt !== 1 || w_cnt !== 1 || ar_cnt !== 1) begin
            n_err++; $display("FAIL zero_ready_pulses: got aw=%0d w=%0d ar=%0d, required 1 1 1", aw_cnt, w_cnt, ar_cnt);
        end
        n_cmp++;
        if (br !== 2'b10 || rr !== 2'b10) begin
            n_err++; $display("FAIL zero_slverr: got bresp=%b rresp=%b, required 10 10", br, rr);
        end
        n_cmp++;
        if (idle_vec !== 5'b0 || z_gpio_o !== 1'b0) begin
            n_err++; $display("FAIL zero_idle: got hs=%b gpio_o=%b, required 00000 0", idle_vec, z_gpio_o);
        end
    endtask

    task automatic test_reset_mid();
        bit          got;
        logic [4:0]  hs;
        int          bseen;
        logic [1:0]  r;
        logic [31:0] d;
        m_if.awaddr = 32'h20; m_if.wdata = 32'h7777_7777; m_if.wstrb = 4'hF;
        m_if.awvalid = 1'b1; m_if.wvalid = 1'b1; m_if.bready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_if.awready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL mid_reset_setup: got no awready, required within 20 cycles"); end
        #2;
        rst = 1'b1;
        #1;
        hs = {m_if.awready, m_if.wready, m_if.arready, m_if.bvalid, m_if.rvalid};
        n_cmp++;
        if (hs !== 5'b0) begin n_err++; $display("FAIL mid_reset_handshake: got %b, required 00000", hs); end
        m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++;
        if (m_gpio_o !== RST_VAL) begin n_err++; $display("FAIL mid_reset_gpio_o: got %h, required %h", m_gpio_o, RST_VAL); end
        rst = 1'b0;
        bseen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_if.bvalid) bseen++;
            @(posedge clk); #1;
        end
        m_if.bready = 1'b0;
        n_cmp++;
        if (bseen !== 0) begin n_err++; $display("FAIL mid_reset_discard: got %0d bvalid cycles, required 0", bseen); end
        axi_read(32'h20, d, r);
        n_cmp++;
        if (d !== RST_VAL || r !== 2'b00) begin
            n_err++; $display("FAIL mid_reset_readback: got %h/%b, required %h/00", d, r, RST_VAL);
        end
    endtask

    // Test sequence
    initial begin
        rst      = 1'b1;
        m_gpio_i = '0;
        z_gpio_i = '0;
        bus_idle();
        test_reset();
        test_write_full();
        test_write_strobe();
        test_input_read();
        test_unmapped();
        test_back_to_back();
        test_concurrent();
        test_zero_ports();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
